// File: rtl/tank_sched.sv
// Tank sprite scheduler: double-buffered 4-slot tank table, per-line row scan,
// and per-pixel lowest-index hit selection with registered renderer outputs.
module tank_sched #(
  parameter int unsigned X_ORG = 160,
  parameter int unsigned Y_ORG = 40,
  parameter int unsigned CELL  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] VGA_xpos,
  input  logic [10:0] VGA_ypos,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [4:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [1:0]  wr_dir,
  input  logic        wr_state,
  input  logic        wr_ide,
  output logic [4:0]  x_rel_pos,
  output logic [4:0]  y_rel_pos,
  output logic [1:0]  tank_dir,
  output logic        tank_state,
  output logic        tank_ide,
  output logic        tank_hit,
  output logic [1:0]  sel_idx,
  output logic        busy
);

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] dir;
    logic       state;
    logic       ide;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRIVE} fsm_t;

  slot_t [3:0] shadow;
  slot_t [3:0] active;
  fsm_t        fsm;
  logic [1:0]  cnt;
  logic [3:0]  row_mask;
  logic        commit;
  logic        hit;
  logic [1:0]  hit_idx;

  // Cell window is centre-10 .. centre+9; 12-bit math keeps the top cell from wrapping.
  function automatic logic in_win(input logic [10:0] pos, input logic [4:0] rel,
                                  input logic [11:0] org);
    logic [11:0] c;
    logic [11:0] lo;
    logic [11:0] hi;
    c  = 12'(rel) * 12'(CELL) + org;
    lo = (c >= 12'd10) ? c - 12'd10 : '0;
    hi = c + 12'd9;
    return ({1'b0, pos} >= lo) && ({1'b0, pos} <= hi);
  endfunction

  assign commit = (VGA_xpos == '0) && (VGA_ypos == '0);

  // Active copies the pre-write shadow on a commit cycle, so a same-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en)
        shadow[wr_idx] <= '{x: wr_x, y: wr_y, dir: wr_dir, state: wr_state, ide: wr_ide};
      if (commit)
        active <= shadow;
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hit && row_mask[i] && in_win(VGA_xpos, active[i].x, 12'(X_ORG))) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      cnt        <= '0;
      row_mask   <= '0;
      busy       <= 1'b0;
      tank_hit   <= 1'b0;
      sel_idx    <= '0;
      x_rel_pos  <= '0;
      y_rel_pos  <= '0;
      tank_dir   <= '0;
      tank_state <= 1'b0;
      tank_ide   <= 1'b0;
    end else begin
      tank_hit <= 1'b0;
      if (VGA_xpos == '0) begin
        fsm  <= SCAN;
        cnt  <= '0;
        busy <= 1'b1;
      end else begin
        case (fsm)
          SCAN: begin
            row_mask[cnt] <= active[cnt].state && in_win(VGA_ypos, active[cnt].y, 12'(Y_ORG));
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              fsm  <= DRIVE;
              busy <= 1'b0;
            end
          end
          DRIVE: begin
            if (hit) begin
              tank_hit   <= 1'b1;
              sel_idx    <= hit_idx;
              x_rel_pos  <= active[hit_idx].x;
              y_rel_pos  <= active[hit_idx].y;
              tank_dir   <= active[hit_idx].dir;
              tank_state <= active[hit_idx].state;
              tank_ide   <= active[hit_idx].ide;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tank_sched.md
TANK_SCHED -- requirements
Module: tank_sched

Interface
REQ-001 Parameter X_ORG, default 160: playfield pixel x of cell column 0 centre.
REQ-002 Parameter Y_ORG, default 40: playfield pixel y of cell row 0 centre.
REQ-003 Parameter CELL, default 20: cell pitch in pixels; cell spans centre-10 .. centre+9 on each axis.
REQ-004 clk  in  1  system pixel clock; sole clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 VGA_xpos  in  11  current scan column.
REQ-007 VGA_ypos  in  11  current scan row.
REQ-008 wr_en  in  1  slot-table write strobe, one write per cycle.
REQ-009 wr_idx  in  2  slot index 0..3.
REQ-010 wr_x, wr_y  in  5 each  tank relative cell position.
REQ-011 wr_dir  in  2  direction (00 up, 01 down, 10 left, 11 right).
REQ-012 wr_state, wr_ide  in  1 each  alive flag; identity (1 = player, 0 = enemy).
REQ-013 x_rel_pos, y_rel_pos  out  5 each  selected tank position, to the renderer.
REQ-014 tank_dir  out  2; tank_state, tank_ide  out  1 each  selected tank attributes.
REQ-015 tank_hit  out  1  current pixel lies inside a live tank's cell.
REQ-016 sel_idx  out  2  index of the selected slot.
REQ-017 busy  out  1  high while the line scan runs.

Function
REQ-018 Block SHALL hold 4 shadow slots (write side) and 4 active slots (render side), each {x, y, dir, state, ide}.
REQ-019 wr_en SHALL update shadow slot wr_idx on the next clk edge; writes are never refused.
REQ-020 On the cycle where VGA_xpos==0 and VGA_ypos==0 (frame commit), all 4 active slots SHALL load the shadow slots.
REQ-021 A write on the commit cycle SHALL land in the shadow slot only; active takes the pre-write shadow value, and the new value appears at the next frame.
REQ-022 FSM states: IDLE, SCAN, DRIVE; reset enters IDLE.
REQ-023 Any state, VGA_xpos==0 -> SCAN with slot counter = 0; this includes restarting a scan in progress.
REQ-024 SCAN SHALL evaluate one slot per cycle (counter 0..3) and set row_mask[i] = active state[i] AND VGA_ypos within [y*CELL+Y_ORG-10, y*CELL+Y_ORG+9].
REQ-025 After slot 3, SCAN -> DRIVE; DRIVE holds until the next VGA_xpos==0; IDLE holds until the first VGA_xpos==0.
REQ-026 SCAN evaluation on the commit line SHALL use the freshly committed active values.
REQ-027 Row arithmetic SHALL be at least 11 bits wide and unsigned; a window whose lower bound would be negative clamps to 0.
REQ-028 In DRIVE, the block SHALL select the lowest index i with row_mask[i]=1 and VGA_xpos within [x*CELL+X_ORG-10, x*CELL+X_ORG+9].
REQ-029 Outputs SHALL be registered with 1-cycle latency: outputs at edge N+1 reflect VGA_xpos/VGA_ypos sampled at edge N.
REQ-030 On a hit, tank_hit=1, sel_idx=i, and x_rel_pos/y_rel_pos/tank_dir/tank_state/tank_ide = active slot i.
REQ-031 On no hit, and throughout IDLE and SCAN, tank_hit=0 and the remaining outputs SHALL hold their last values.
REQ-032 busy SHALL be 1 exactly in SCAN (4 cycles per full scan).
REQ-033 Overlapping tanks: the lowest index wins; higher indices are never reported for that pixel.

Reset
REQ-034 On rst=1 at a clk edge, every output SHALL be 0, all shadow and active slots and row_mask SHALL be 0, and the FSM SHALL be IDLE.
REQ-035 rst mid-SCAN or mid-DRIVE SHALL abort immediately; tank_hit=0 from the next edge until a new scan completes.
REQ-036 Writes presented during rst SHALL be ignored.

Verification
REQ-037 Write slot0 {x=2,y=3,state=1,ide=1,dir=00} and run a commit. On row 100, xpos 190..209 -> tank_hit=1, sel_idx=0, x_rel_pos=2 one cycle later; xpos 189 or 210 -> tank_hit=0.
REQ-038 Slot1 and slot2 both set to x=5,y=5 and live. At pixel (260,140) -> sel_idx=1; kill slot1 and commit -> sel_idx=2.
REQ-039 Write slot0 x=7 mid-frame -> render still uses the old x until the next commit; a write on the commit cycle is deferred one more frame.
REQ-040 Pulse VGA_xpos==0 at scan cycle 2 -> busy stays high 4 further cycles and the scan restarts at slot 0.
REQ-041 Assert rst during DRIVE while tank_hit=1 -> all outputs are 0 next edge and tank_hit stays 0 through the rest of the line.
REQ-042 Slot with state=0 at a matching position -> tank_hit never asserts for it.
